reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STRETCH_CYCLES, default 15, meaning reset hold time after PLL lock, in CLK cycles (min 1).
REQ-002 SHALL have parameter STAGGER_CYCLES, default 4, meaning delay between successive domain releases (min 1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable samples required to change the button level (min 2).
REQ-004 SHALL have port CLK  in  1: single clock (hclk); all logic in this domain.
REQ-005 SHALL have port PORESETn  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port PLL_LOCKED  in  1: MMCM lock, asynchronous.
REQ-007 SHALL have port BUTTON_n  in  1: pushbutton, asynchronous, low = pressed.
REQ-008 SHALL have port SYSRESETREQ  in  1: core soft-reset request, level, CLK-synchronous.
REQ-009 SHALL have port DBG_RESET_REQ  in  1: host transport soft-reset request, CLK-synchronous.
REQ-010 SHALL have port CAUSE_CLR  in  1: clears RESET_CAUSE, single-cycle pulse.
REQ-011 SHALL have port TRANSPORT_RESETn  out  1: transport domain reset.
REQ-012 SHALL have port BUS_RESETn  out  1: AHB fabric reset.
REQ-013 SHALL have port CORE_RESETn  out  1: CM3 core reset.
REQ-014 SHALL have port READY  out  1: high only in RUN.
REQ-015 SHALL have port RESET_CAUSE  out  3: sticky cause, bit0 lock/POR, bit1 button, bit2 soft.

Function
REQ-016 SHALL synchronise PLL_LOCKED and BUTTON_n through 2-flop synchronisers, giving 2 edges of latency.
REQ-017 SHALL debounce BUTTON_n: the debounced pressed level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-018 SHALL use FSM states WAIT_LOCK, STRETCH, REL_BUS, REL_CORE, RUN, plus a soft flag.
REQ-019 WAIT_LOCK -> STRETCH SHALL occur on the edge where synchronised lock = 1; all outputs stay low in WAIT_LOCK.
REQ-020 STRETCH SHALL last exactly STRETCH_CYCLES cycles, then go to REL_BUS, setting TRANSPORT_RESETn = 1 on that edge.
REQ-021 REL_BUS SHALL last STAGGER_CYCLES cycles, then go to REL_CORE, setting BUS_RESETn = 1 on that edge.
REQ-022 REL_CORE SHALL last STAGGER_CYCLES cycles, then go to RUN, setting CORE_RESETn = 1 and READY = 1 on that edge.
REQ-023 Lock loss (synchronised lock = 0) in any state SHALL, on the next edge: drive all resets and READY low, go to WAIT_LOCK, clear the soft flag, and set RESET_CAUSE bit0.
REQ-024 A debounced press in any state except WAIT_LOCK SHALL, on the next edge:
- drive all resets and READY low;
- enter STRETCH, reloading the counter every cycle while pressed;
- set RESET_CAUSE bit1.
REQ-025 After button release, the button-initiated STRETCH SHALL count a full STRETCH_CYCLES.
REQ-026 SYSRESETREQ or DBG_RESET_REQ high in RUN SHALL, on the next edge, drive BUS_RESETn, CORE_RESETn and READY low, enter STRETCH with the soft flag set, and set RESET_CAUSE bit2.
REQ-027 During a soft reset, TRANSPORT_RESETn SHALL remain 1 throughout.
REQ-028 Soft reset requests outside RUN SHALL be ignored.
REQ-029 Simultaneous events SHALL be prioritised: lock loss > button > soft request.
REQ-030 A lock loss or button press during a soft sequence SHALL convert it to a full sequence (soft flag cleared, TRANSPORT_RESETn low).
REQ-031 Counters SHALL be $clog2(max(parameter)+1) bits wide, count down to 0, never wrap, and reload on every state entry.
REQ-032 All outputs SHALL be registered, deasserting only on CLK edges.
REQ-033 CAUSE_CLR SHALL zero RESET_CAUSE on the next edge; a same-edge new cause SHALL win over the clear.

Reset
REQ-034 PORESETn low SHALL asynchronously force:
- TRANSPORT_RESETn, BUS_RESETn, CORE_RESETn and READY = 0;
- FSM = WAIT_LOCK, counters = 0, soft flag = 0;
- synchronisers to unlocked / not pressed;
- debounce counter = 0;
- RESET_CAUSE = 3'b001.
REQ-035 PORESETn assertion mid-sequence SHALL abort the sequence immediately, with no glitch on any output while asserted.

Verification
REQ-036 Defaults, PLL_LOCKED = 1, PORESETn released before edge 1 -> TRANSPORT_RESETn rises at edge 18, BUS_RESETn at 22, CORE_RESETn and READY at 26.
REQ-037 In RUN, a 1-cycle SYSRESETREQ at edge N -> BUS/CORE low at N+1, TRANSPORT stays 1, BUS high at N+20, CORE at N+24, RESET_CAUSE = 3'b101.
REQ-038 In RUN, PLL_LOCKED low for 1 us -> all outputs low 3 edges after the drop; sequence restarts after relock; RESET_CAUSE bit0 = 1.
REQ-039 BUTTON_n low for 10 cycles -> no effect; low for 40 cycles -> full reset, with release timing measured from the debounced release, RESET_CAUSE bit1 = 1.
REQ-040 Soft request and lock loss on the same edge -> WAIT_LOCK, TRANSPORT_RESETn low, RESET_CAUSE = 3'b001 (bit2 not set).
REQ-041 PORESETn pulsed low during REL_CORE -> all outputs 0 asynchronously; sequence restarts cleanly on release.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / soft reset sequencer: lock-gated stretch, then staggered transport -> bus -> core release.
// Latency: 2-flop sync + STRETCH_CYCLES + 2*STAGGER_CYCLES edges; no backpressure, all outputs registered.
module reset_sequencer #(
  parameter int STRETCH_CYCLES  = 15,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       PORESETn,
  input  logic       PLL_LOCKED,
  input  logic       BUTTON_n,
  input  logic       SYSRESETREQ,
  input  logic       DBG_RESET_REQ,
  input  logic       CAUSE_CLR,
  output logic       TRANSPORT_RESETn,
  output logic       BUS_RESETn,
  output logic       CORE_RESETn,
  output logic       READY,
  output logic [2:0] RESET_CAUSE
);

  localparam int MAX_SQ = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int MAX_P  = (MAX_SQ > DEBOUNCE_CYCLES) ? MAX_SQ : DEBOUNCE_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LD = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STRETCH   = 3'd1,
    REL_BUS   = 3'd2,
    REL_CORE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  logic          lock_s1, lock_s2;
  logic          btn_s1, btn_s2;
  logic          btn_pressed;
  logic [CW-1:0] db_cnt;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          soft_q, soft_d;
  logic          trn_d, bus_d, core_d, rdy_d;
  logic [2:0]    cause_set;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
    end else begin
      lock_s1 <= PLL_LOCKED;
      lock_s2 <= lock_s1;
      btn_s1  <= BUTTON_n;
      btn_s2  <= btn_s1;
    end
  end

  // db_cnt counts consecutive samples that disagree with the current debounced level
  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      btn_pressed <= 1'b0;
      db_cnt      <= '0;
    end else if (~btn_s2 == btn_pressed) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_pressed <= ~btn_s2;
      db_cnt      <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    soft_d    = soft_q;
    trn_d     = TRANSPORT_RESETn;
    bus_d     = BUS_RESETn;
    core_d    = CORE_RESETn;
    rdy_d     = READY;
    cause_set = 3'b000;

    if (!lock_s2) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      soft_d  = 1'b0;
      trn_d   = 1'b0;
      bus_d   = 1'b0;
      core_d  = 1'b0;
      rdy_d   = 1'b0;
      if (state_q != WAIT_LOCK) cause_set[0] = 1'b1;
    end else if (btn_pressed && (state_q != WAIT_LOCK)) begin
      // held in STRETCH with a fresh count until the debounced release
      state_d      = STRETCH;
      cnt_d        = STRETCH_LD;
      soft_d       = 1'b0;
      trn_d        = 1'b0;
      bus_d        = 1'b0;
      core_d       = 1'b0;
      rdy_d        = 1'b0;
      cause_set[1] = 1'b1;
    end else if ((SYSRESETREQ || DBG_RESET_REQ) && (state_q == RUN)) begin
      state_d      = STRETCH;
      cnt_d        = STRETCH_LD;
      soft_d       = 1'b1;
      bus_d        = 1'b0;
      core_d       = 1'b0;
      rdy_d        = 1'b0;
      cause_set[2] = 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = STRETCH;
          cnt_d   = STRETCH_LD;
        end
        STRETCH: begin
          trn_d = soft_q;
          if (cnt_q == '0) begin
            state_d = REL_BUS;
            cnt_d   = STAGGER_LD;
            trn_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        REL_BUS: begin
          if (cnt_q == '0) begin
            state_d = REL_CORE;
            cnt_d   = STAGGER_LD;
            bus_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        REL_CORE: begin
          if (cnt_q == '0) begin
            state_d = RUN;
            soft_d  = 1'b0;
            core_d  = 1'b1;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          soft_d  = 1'b0;
          trn_d   = 1'b0;
          bus_d   = 1'b0;
          core_d  = 1'b0;
          rdy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      soft_q           <= 1'b0;
      TRANSPORT_RESETn <= 1'b0;
      BUS_RESETn       <= 1'b0;
      CORE_RESETn      <= 1'b0;
      READY            <= 1'b0;
      RESET_CAUSE      <= 3'b001;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      soft_q           <= soft_d;
      TRANSPORT_RESETn <= trn_d;
      BUS_RESETn       <= bus_d;
      CORE_RESETn      <= core_d;
      READY            <= rdy_d;
      // a cause raised on the same edge as a clear survives it
      RESET_CAUSE      <= (CAUSE_CLR ? 3'b000 : RESET_CAUSE) | cause_set;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output transitions queued with their edge number.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       PORESETn = 1'b1;
  logic       PLL_LOCKED = 1'b1;
  logic       BUTTON_n = 1'b1;
  logic       SYSRESETREQ = 1'b0;
  logic       DBG_RESET_REQ = 1'b0;
  logic       CAUSE_CLR = 1'b0;
  logic       TRANSPORT_RESETn, BUS_RESETn, CORE_RESETn, READY;
  logic [2:0] RESET_CAUSE;

  reset_sequencer dut (
    .CLK              (CLK),
    .PORESETn         (PORESETn),
    .PLL_LOCKED       (PLL_LOCKED),
    .BUTTON_n         (BUTTON_n),
    .SYSRESETREQ      (SYSRESETREQ),
    .DBG_RESET_REQ    (DBG_RESET_REQ),
    .CAUSE_CLR        (CAUSE_CLR),
    .TRANSPORT_RESETn (TRANSPORT_RESETn),
    .BUS_RESETn       (BUS_RESETn),
    .CORE_RESETn      (CORE_RESETn),
    .READY            (READY),
    .RESET_CAUSE      (RESET_CAUSE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [3:0] outs;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] outs;
  logic [3:0] prev_outs = 4'b0000;

  assign outs = {TRANSPORT_RESETn, BUS_RESETn, CORE_RESETn, READY};

  // edge number since PORESETn release; edge 1 is the first posedge after release
  always @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [3:0] o);
    exp_t e;
    e.cyc  = c;
    e.outs = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (cyc < c) check_val("wait_timeout", cyc, c);
  endtask

  task automatic clear_cause();
    CAUSE_CLR = 1'b1;
    @(negedge CLK);
    CAUSE_CLR = 1'b0;
    check_val("cause_clr", RESET_CAUSE, 3'b000);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (PORESETn && outs != prev_outs) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_change", outs, prev_outs);
      end else begin
        e = exp_q.pop_front();
        check_val("trans_edge", cyc, e.cyc);
        check_val("trans_outs", outs, e.outs);
      end
    end
    prev_outs = outs;
  end

  initial begin
    int n;
    #1 PORESETn = 1'b0;
    #1;
    check_val("rst_outs", outs, 4'b0000);
    check_val("rst_cause", RESET_CAUSE, 3'b001);

    // Power-up with lock already present
    repeat (2) @(negedge CLK);
    push_exp(18, 4'b1000);
    push_exp(22, 4'b1100);
    push_exp(26, 4'b1111);
    PORESETn = 1'b1;
    wait_cyc(30);
    check_val("bringup_ready", READY, 1'b1);
    check_val("bringup_cause", RESET_CAUSE, 3'b001);

    // Single-cycle core soft reset: transport stays released
    n = cyc;
    push_exp(n + 1, 4'b1000);
    push_exp(n + 20, 4'b1100);
    push_exp(n + 24, 4'b1111);
    SYSRESETREQ = 1'b1;
    @(negedge CLK);
    SYSRESETREQ = 1'b0;
    wait_cyc(n + 30);
    check_val("soft_cause", RESET_CAUSE, 3'b101);
    clear_cause();

    // Debug soft reset colliding with a clear; late requests mid-sequence are ignored
    n = cyc;
    push_exp(n + 1, 4'b1000);
    push_exp(n + 20, 4'b1100);
    push_exp(n + 24, 4'b1111);
    DBG_RESET_REQ = 1'b1;
    CAUSE_CLR     = 1'b1;
    @(negedge CLK);
    DBG_RESET_REQ = 1'b0;
    CAUSE_CLR     = 1'b0;
    check_val("clr_vs_new_cause", RESET_CAUSE, 3'b100);
    wait_cyc(n + 5);
    SYSRESETREQ = 1'b1;
    @(negedge CLK);
    SYSRESETREQ = 1'b0;
    wait_cyc(n + 21);
    DBG_RESET_REQ = 1'b1;
    @(negedge CLK);
    DBG_RESET_REQ = 1'b0;
    wait_cyc(n + 30);
    check_val("dbg_cause", RESET_CAUSE, 3'b100);
    clear_cause();

    // Short button glitch is filtered
    n = cyc;
    BUTTON_n = 1'b0;
    wait_cyc(n + 10);
    BUTTON_n = 1'b1;
    wait_cyc(n + 40);
    check_val("glitch_cause", RESET_CAUSE, 3'b000);
    check_val("glitch_ready", READY, 1'b1);

    // Long press: full reset, stretch counted from the debounced release
    n = cyc;
    push_exp(n + 19, 4'b0000);
    push_exp(n + 73, 4'b1000);
    push_exp(n + 77, 4'b1100);
    push_exp(n + 81, 4'b1111);
    BUTTON_n = 1'b0;
    wait_cyc(n + 40);
    check_val("press_core_low", CORE_RESETn, 1'b0);
    BUTTON_n = 1'b1;
    wait_cyc(n + 90);
    check_val("button_cause", RESET_CAUSE, 3'b010);
    clear_cause();

    // Lock loss for 1 us in RUN
    n = cyc;
    push_exp(n + 3, 4'b0000);
    push_exp(n + 118, 4'b1000);
    push_exp(n + 122, 4'b1100);
    push_exp(n + 126, 4'b1111);
    PLL_LOCKED = 1'b0;
    wait_cyc(n + 100);
    PLL_LOCKED = 1'b1;
    wait_cyc(n + 135);
    check_val("lock_cause", RESET_CAUSE, 3'b001);
    clear_cause();

    // Soft request and lock loss reach the FSM on the same edge
    n = cyc;
    push_exp(n + 3, 4'b0000);
    push_exp(n + 38, 4'b1000);
    push_exp(n + 42, 4'b1100);
    push_exp(n + 46, 4'b1111);
    PLL_LOCKED = 1'b0;
    wait_cyc(n + 2);
    SYSRESETREQ = 1'b1;
    @(negedge CLK);
    SYSRESETREQ = 1'b0;
    wait_cyc(n + 5);
    check_val("collide_cause", RESET_CAUSE, 3'b001);
    check_val("collide_transport", TRANSPORT_RESETn, 1'b0);
    wait_cyc(n + 20);
    PLL_LOCKED = 1'b1;
    wait_cyc(n + 50);
    check_val("collide_ready", READY, 1'b1);

    // PORESETn pulse during REL_CORE of a soft sequence
    n = cyc;
    push_exp(n + 1, 4'b1000);
    push_exp(n + 20, 4'b1100);
    SYSRESETREQ = 1'b1;
    @(negedge CLK);
    SYSRESETREQ = 1'b0;
    wait_cyc(n + 22);
    #2 PORESETn = 1'b0;
    #1;
    check_val("por_async_outs", outs, 4'b0000);
    check_val("por_async_cause", RESET_CAUSE, 3'b001);
    repeat (2) @(negedge CLK);
    check_val("por_held_outs", outs, 4'b0000);
    push_exp(18, 4'b1000);
    push_exp(22, 4'b1100);
    push_exp(26, 4'b1111);
    PORESETn = 1'b1;
    wait_cyc(30);
    check_val("por_restart_ready", READY, 1'b1);

    check_val("pending_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
